inv_checker: RTL and testbench

Self-checking receiver for the inverter problem set. It samples the stimulus driven into a unit under test and the unit's output on every clock. It compares the output against the inverted stimulus, delayed to match the unit's latency, over a fixed-length run. It reports mismatch count, first-failure index, output activity and pass/fail, so benches and on-board tests no longer rely on waveform inspection.

---
 rtl/inv_checker.sv | 118 +++++++++++
 tb/tb_inv_checker.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/inv_checker.sv
// rtl/inv_checker.sv - self-checking receiver comparing a unit's output against the delayed inverted stimulus
// Optional toggle counter and toggle-aware verdict: INV_CHECK_TOGGLE_EN
module inv_checker #(
    parameter int NSAMPLES = 16,
    parameter int CNT_W    = 8,
    parameter int DELAY    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in,
    input  logic             out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err,
    output logic [CNT_W-1:0] toggle_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] idx;
    logic [3:0]       fill_cnt;
    logic             in_d;
    logic             accept;
    logic             mism;
    logic             verdict;

    assign accept = (state == S_IDLE) && start;
    assign mism   = (out == in_d);

    // Delay line runs in every state so it is already primed when FILL ends.
    generate
        if (DELAY == 0) begin : g_nodelay
            assign in_d = in;
        end else begin : g_delay
            logic [DELAY-1:0] dl;
            always_ff @(posedge clk) begin
                if (rst) dl <= '0;
                else     dl <= DELAY'({dl, in});
            end
            assign in_d = dl[DELAY-1];
        end
    endgenerate

`ifdef INV_CHECK_TOGGLE_EN
    logic prev_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            toggle_cnt <= '0;
            prev_out   <= 1'b0;
        end else if (accept) begin
            toggle_cnt <= '0;
        end else if (state == S_RUN) begin
            prev_out <= out;
            if ((idx != '0) && (out != prev_out) && (toggle_cnt != '1))
                toggle_cnt <= toggle_cnt + 1'b1;
        end
    end

    // A stuck output can match a constant stimulus, so demand some activity.
    assign verdict = (err_cnt == '0) && (toggle_cnt != '0);
`else
    assign toggle_cnt = '0;
    assign verdict    = (err_cnt == '0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= '0;
            first_err <= '1;
            idx       <= '0;
            fill_cnt  <= '0;
        end else begin
            done <= 1'b0;
            // busy stays up through the done cycle and drops the edge after.
            busy <= accept || (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        err_cnt   <= '0;
                        first_err <= '1;
                        idx       <= '0;
                        fill_cnt  <= '0;
                        pass      <= 1'b0;
                        state     <= (DELAY == 0) ? S_RUN : S_FILL;
                    end
                end
                S_FILL: begin
                    if (fill_cnt == 4'(DELAY - 1)) state <= S_RUN;
                    else                           fill_cnt <= fill_cnt + 1'b1;
                end
                S_RUN: begin
                    if (mism) begin
                        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                        if (err_cnt == '0) first_err <= idx;
                    end
                    if (idx == CNT_W'(NSAMPLES - 1)) state <= S_DONE;
                    else                             idx   <= idx + 1'b1;
                end
                S_DONE: begin
                    done  <= 1'b1;
                    pass  <= verdict;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_checker.sv
// tb/tb_inv_checker.sv - randomized bench for inv_checker with a sample-array reference model
module tb_inv_checker;
    localparam int N = 16;
`ifdef INV_CHECK_TOGGLE_EN
    localparam bit TOG = 1'b1;
`else
    localparam bit TOG = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, start = 1'b0, in_s = 1'b0, out_s = 1'b0;
    logic busy0, done0, pass0, busy1, done1, pass1;
    logic [7:0] err0, first0, tog0, err1, first1, tog1;

    inv_checker #(.NSAMPLES(N), .CNT_W(8), .DELAY(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .in(in_s), .out(out_s),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_cnt(err0), .first_err(first0), .toggle_cnt(tog0));

    inv_checker #(.NSAMPLES(N), .CNT_W(8), .DELAY(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .in(in_s), .out(out_s),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err1), .first_err(first1), .toggle_cnt(tog1));

    int total = 0, bad = 0;
    bit in_arr[64], out_arr[64];
    int dat[2], dcnt[2];
    bit bz[2][64];
    int e_err, e_first, e_tog;
    bit e_pass;

    // Element c of in_arr/out_arr is the value present at edge t+c, t = start edge.
    // Sample k happens at edge t+1+d+k and is compared with the inverse of in at edge t+1+k.
    function automatic void model(input int d);
        bit o;
        e_err = 0; e_first = 255; e_tog = 0;
        for (int k = 0; k < N; k++) begin
            o = out_arr[1 + d + k];
            if (o == in_arr[1 + k]) begin
                if (e_err == 0) e_first = k;
                if (e_err < 255) e_err++;
            end
            if (TOG && k > 0 && o != out_arr[d + k] && e_tog < 255) e_tog++;
        end
        e_pass = (e_err == 0) && (!TOG || e_tog >= 1);
    endfunction

    task automatic drive_run(input int scyc);
        dat[0] = -1; dat[1] = -1; dcnt[0] = 0; dcnt[1] = 0;
        @(negedge clk);
        start = 1'b1; in_s = in_arr[0]; out_s = out_arr[0];
        for (int c = 0; c < 40; c++) begin
            if (c > 0) begin
                @(negedge clk);
                start = (c == scyc); in_s = in_arr[c]; out_s = out_arr[c];
            end
            @(posedge clk); #1;
            bz[0][c] = busy0; bz[1][c] = busy1;
            if (done0) begin dcnt[0]++; if (dat[0] < 0) dat[0] = c; end
            if (done1) begin dcnt[1]++; if (dat[1] < 0) dat[1] = c; end
        end
        @(negedge clk); start = 1'b0;
    endtask

    task automatic fill_toggle(input bit inverter);
        bit ph;
        ph = 1'($urandom_range(0, 1));
        for (int c = 0; c < 64; c++) begin
            in_arr[c]  = ph ^ c[0];
            out_arr[c] = inverter ? ~in_arr[c] : in_arr[c];
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; in_s = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total += 6;
        if (busy0 !== 1'b0)   begin bad++; $display("FAIL reset_busy: got %b want 0", busy0); end
        if (done0 !== 1'b0)   begin bad++; $display("FAIL reset_done: got %b want 0", done0); end
        if (pass0 !== 1'b0)   begin bad++; $display("FAIL reset_pass: got %b want 0", pass0); end
        if (err0 !== 8'h00)   begin bad++; $display("FAIL reset_err: got %h want 00", err0); end
        if (first0 !== 8'hFF) begin bad++; $display("FAIL reset_first: got %h want ff", first0); end
        if (tog0 !== 8'h00)   begin bad++; $display("FAIL reset_tog: got %h want 00", tog0); end
        @(negedge clk); rst = 1'b0; start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ideal;
        fill_toggle(1'b1);
        drive_run(0);
        total += 8;
        if (dat[0] !== 17)  begin bad++; $display("FAIL ideal_done_at: got %0d want 17", dat[0]); end
        if (dcnt[0] !== 1)  begin bad++; $display("FAIL ideal_done_len: got %0d want 1", dcnt[0]); end
        if (bz[0][1] !== 1'b1 || bz[0][17] !== 1'b1)
            begin bad++; $display("FAIL ideal_busy_hi: got %b%b want 11", bz[0][1], bz[0][17]); end
        if (bz[0][18] !== 1'b0) begin bad++; $display("FAIL ideal_busy_fall: got %b want 0", bz[0][18]); end
        if (err0 !== 8'd0)      begin bad++; $display("FAIL ideal_err: got %0d want 0", err0); end
        if (first0 !== 8'hFF)   begin bad++; $display("FAIL ideal_first: got %h want ff", first0); end
        if (tog0 !== (TOG ? 8'd15 : 8'd0))
            begin bad++; $display("FAIL ideal_tog: got %0d want %0d", tog0, TOG ? 15 : 0); end
        if (pass0 !== 1'b1)     begin bad++; $display("FAIL ideal_pass: got %b want 1", pass0); end
    endtask

    task automatic test_buffer;
        fill_toggle(1'b0);
        drive_run(0);
        total += 3;
        if (err0 !== 8'd16)   begin bad++; $display("FAIL buffer_err: got %0d want 16", err0); end
        if (first0 !== 8'd0)  begin bad++; $display("FAIL buffer_first: got %0d want 0", first0); end
        if (pass0 !== 1'b0)   begin bad++; $display("FAIL buffer_pass: got %b want 0", pass0); end
    endtask

    task automatic test_single_err;
        fill_toggle(1'b1);
        out_arr[6] = in_arr[6];
        drive_run(0);
        total += 3;
        if (err0 !== 8'd1)    begin bad++; $display("FAIL single_err: got %0d want 1", err0); end
        if (first0 !== 8'd5)  begin bad++; $display("FAIL single_first: got %0d want 5", first0); end
        if (pass0 !== 1'b0)   begin bad++; $display("FAIL single_pass: got %b want 0", pass0); end
    endtask

    task automatic test_stuck;
        for (int c = 0; c < 64; c++) begin in_arr[c] = 1'b0; out_arr[c] = 1'b1; end
        drive_run(0);
        total += 3;
        if (err0 !== 8'd0)   begin bad++; $display("FAIL stuck_err: got %0d want 0", err0); end
        if (tog0 !== 8'd0)   begin bad++; $display("FAIL stuck_tog: got %0d want 0", tog0); end
        if (pass0 !== !TOG)  begin bad++; $display("FAIL stuck_pass: got %b want %b", pass0, !TOG); end
    endtask

    task automatic test_registered;
        fill_toggle(1'b1);
        for (int c = 63; c > 0; c--) out_arr[c] = ~in_arr[c - 1];
        drive_run(0);
        total += 4;
        if (dat[1] !== 18)   begin bad++; $display("FAIL reg_done_at: got %0d want 18", dat[1]); end
        if (pass1 !== 1'b1)  begin bad++; $display("FAIL reg_pass_d1: got %b want 1", pass1); end
        if (err1 !== 8'd0)   begin bad++; $display("FAIL reg_err_d1: got %0d want 0", err1); end
        if (err0 !== 8'd16)  begin bad++; $display("FAIL reg_err_d0: got %0d want 16", err0); end
    endtask

    task automatic test_rst_mid;
        int dn;
        dn = 0;
        fill_toggle(1'b0);
        @(negedge clk);
        start = 1'b1; in_s = in_arr[0]; out_s = out_arr[0];
        for (int c = 1; c < 30; c++) begin
            @(negedge clk);
            start = 1'b0; rst = (c == 9); in_s = in_arr[c]; out_s = out_arr[c];
            @(posedge clk); #1;
            if (done0) dn++;
            if (c == 9) begin
                total += 4;
                if (busy0 !== 1'b0)   begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy0); end
                if (err0 !== 8'd0)    begin bad++; $display("FAIL rstmid_err: got %0d want 0", err0); end
                if (first0 !== 8'hFF) begin bad++; $display("FAIL rstmid_first: got %h want ff", first0); end
                if (pass0 !== 1'b0 || tog0 !== 8'd0)
                    begin bad++; $display("FAIL rstmid_pass_tog: got %b/%0d want 0/0", pass0, tog0); end
            end
        end
        @(negedge clk); rst = 1'b0;
        total++;
        if (dn !== 0) begin bad++; $display("FAIL rstmid_no_done: got %0d want 0", dn); end
        fill_toggle(1'b1);
        drive_run(6);
        total += 2;
        if (dat[0] !== 17)  begin bad++; $display("FAIL rstmid_fresh_done_at: got %0d want 17", dat[0]); end
        if (pass0 !== 1'b1) begin bad++; $display("FAIL rstmid_fresh_pass: got %b want 1", pass0); end
    endtask

    task automatic test_random;
        int r, scyc;
        bit bo, po;
        logic [7:0] eo, fo, to;
        for (int it = 0; it < 8; it++) begin
            r = $urandom_range(0, 1);
            for (int c = 0; c < 64; c++) begin
                in_arr[c] = 1'($urandom_range(0, 1));
                out_arr[c] = (c >= r) ? ~in_arr[c - r] : 1'($urandom_range(0, 1));
                if ($urandom_range(0, 5) == 0) out_arr[c] = ~out_arr[c];
            end
            scyc = (it % 3 == 0) ? 0 : ((it % 3 == 1) ? 6 : N + 1);
            drive_run(scyc);
            for (int d = 0; d < 2; d++) begin
                model(d);
                eo = d ? err1 : err0; fo = d ? first1 : first0; to = d ? tog1 : tog0;
                po = d ? pass1 : pass0; bo = bz[d][d + N + 2];
                total += 6;
                if (dat[d] !== d + N + 1) begin bad++; $display("FAIL rand%0d_d%0d_done_at: got %0d want %0d", it, d, dat[d], d + N + 1); end
                if (bo !== 1'b0)          begin bad++; $display("FAIL rand%0d_d%0d_busy_fall: got %b want 0", it, d, bo); end
                if (eo !== 8'(e_err))     begin bad++; $display("FAIL rand%0d_d%0d_err: got %0d want %0d", it, d, eo, e_err); end
                if (fo !== 8'(e_first))   begin bad++; $display("FAIL rand%0d_d%0d_first: got %0d want %0d", it, d, fo, e_first); end
                if (to !== 8'(e_tog))     begin bad++; $display("FAIL rand%0d_d%0d_tog: got %0d want %0d", it, d, to, e_tog); end
                if (po !== e_pass)        begin bad++; $display("FAIL rand%0d_d%0d_pass: got %b want %b", it, d, po, e_pass); end
            end
        end
    endtask

    initial begin
        test_reset;
        test_ideal;
        test_buffer;
        test_single_err;
        test_stuck;
        test_registered;
        test_rst_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
